// File: rtl/alu_seq_mul.sv
// Iterative radix-2 shift-add multiplier: one operand pair in, a 2*WIDTH-bit product out after WIDTH cycles.
// Optional signed operation is enabled by defining ALU_MUL_SIGNED_EN.
module alu_seq_mul #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef ALU_MUL_SIGNED_EN
    input  logic             op_signed,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] prod_lo,
    output logic [WIDTH-1:0] prod_hi
);

    localparam int unsigned CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned PROD_W = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [WIDTH:0]     acc_q, acc_d;
    logic [WIDTH-1:0]   prod_hi_q, prod_hi_d;
    logic [WIDTH-1:0]   prod_lo_q, prod_lo_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q, in_ready_d;

    logic [WIDTH-1:0]   addend_c;
    logic [WIDTH:0]     sum_c;
    logic [PROD_W-1:0]  full_c;
    logic [PROD_W-1:0]  result_c;
    logic [WIDTH-1:0]   a_in_c;
    logic [WIDTH-1:0]   b_in_c;

`ifdef ALU_MUL_SIGNED_EN
    logic               neg_q, neg_d;
`endif

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            prod_hi_q   <= '0;
            prod_lo_q   <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
`ifdef ALU_MUL_SIGNED_EN
            neg_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            prod_hi_q   <= prod_hi_d;
            prod_lo_q   <= prod_lo_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
`ifdef ALU_MUL_SIGNED_EN
            neg_q       <= neg_d;
`endif
        end
    end

    // Next-state, one shift-add step per RUN cycle
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        prod_hi_d   = prod_hi_q;
        prod_lo_d   = prod_lo_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;

        addend_c = mplier_q[0] ? mcand_q : '0;
        sum_c    = acc_q + {1'b0, addend_c};
        // Final {acc, multiplier} after the last right shift
        full_c   = {sum_c, mplier_q[WIDTH-1:1]};

`ifdef ALU_MUL_SIGNED_EN
        neg_d    = neg_q;
        a_in_c   = (op_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
        b_in_c   = (op_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
        result_c = neg_q ? (~full_c + PROD_W'(1)) : full_c;
`else
        a_in_c   = a;
        b_in_c   = b;
        result_c = full_c;
`endif

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d    = a_in_c;
                    mplier_d   = b_in_c;
                    acc_d      = '0;
                    count_d    = '0;
                    in_ready_d = 1'b0;
                    state_d    = RUN;
`ifdef ALU_MUL_SIGNED_EN
                    neg_d      = op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
`endif
                end
            end
            RUN: begin
                acc_d    = {1'b0, sum_c[WIDTH:1]};
                mplier_d = {sum_c[0], mplier_q[WIDTH-1:1]};
                count_d  = count_q + CNT_W'(1);
                if (count_q == CNT_W'(WIDTH - 1)) begin
                    prod_hi_d   = result_c[PROD_W-1:WIDTH];
                    prod_lo_d   = result_c[WIDTH-1:0];
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign prod_hi   = prod_hi_q;
    assign prod_lo   = prod_lo_q;

endmodule

// File: tb/tb_alu_seq_mul.sv
// Self-checking bench for alu_seq_mul: directed operations with a product scoreboard.
module tb_alu_seq_mul;

    localparam int unsigned WIDTH = 32;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             op_signed;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] prod_lo;
    logic [WIDTH-1:0] prod_hi;

    int checks;
    int fails;
    logic [63:0] sb[$];

    alu_seq_mul #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
`ifdef ALU_MUL_SIGNED_EN
        .op_signed (op_signed),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .prod_lo   (prod_lo),
        .prod_hi   (prod_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y, input logic s);
        longint sx;
        longint sy;
        if (s) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            return 64'(sx * sy);
        end
        return 64'(x) * 64'(y);
    endfunction

    task automatic chk64(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic chk32(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic start_op(input logic [31:0] x, input logic [31:0] y, input logic s);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk1("in_ready_before_accept", in_ready, 1'b1);
        a = x; b = y; op_signed = s; in_valid = 1'b1;
        sb.push_back(model(x, y, s));
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk1("in_ready_after_accept", in_ready, 1'b0);
    endtask

    task automatic wait_done(input string tag, input bit toggle);
        int lat;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 200) begin
            if (toggle) begin
                a = $urandom; b = $urandom; in_valid = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1; lat++;
        end
        in_valid = 1'b0;
        chk32({tag, "_latency"}, lat, WIDTH);
    endtask

    task automatic check_result(input string tag);
        logic [63:0] exp;
        if (sb.size() == 0) begin
            checks++; fails++;
            $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
        end else begin
            exp = sb.pop_front();
            chk64(tag, {prod_hi, prod_lo}, exp);
        end
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk1({tag, "_out_valid_drop"}, out_valid, 1'b0);
        chk1({tag, "_in_ready_back"}, in_ready, 1'b1);
    endtask

    task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] y, input logic s);
        start_op(x, y, s);
        wait_done(tag, 1'b0);
        check_result(tag);
        handshake(tag);
    endtask

    initial begin
        logic [63:0] snap;
        checks = 0; fails = 0;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op_signed = 1'b0; a = '0; b = '0;

        // Reset state
        #12;
        chk1("reset_out_valid", out_valid, 1'b0);
        chk64("reset_prod", {prod_hi, prod_lo}, 64'h0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk1("reset_in_ready", in_ready, 1'b1);

        run_op("basic_3x5", 32'd3, 32'd5, 1'b0);
        chk64("basic_value", {prod_hi, prod_lo}, 64'h0000_0000_0000_000F);
        chk64("retain_after_handshake", {prod_hi, prod_lo}, 64'hF);
        run_op("max_unsigned", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        chk64("max_value", {prod_hi, prod_lo}, 64'hFFFF_FFFE_0000_0001);
        run_op("zero_a", 32'h0, 32'hFFFF_FFFF, 1'b0);
        run_op("zero_b", 32'hDEAD_BEEF, 32'h0, 1'b0);
        run_op("misc", 32'h8000_0000, 32'h0000_0003, 1'b0);

        // Backpressure with a competing request held in DONE
        start_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        wait_done("bp", 1'b0);
        snap = {prod_hi, prod_lo};
        a = 32'd11; b = 32'd13; in_valid = 1'b1; out_ready = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            chk64("bp_stable", {prod_hi, prod_lo}, snap);
            chk1("bp_in_ready_low", in_ready, 1'b0);
            chk1("bp_out_valid_high", out_valid, 1'b1);
        end
        check_result("bp_value");
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk1("bp_hs_out_valid", out_valid, 1'b0);
        chk1("bp_hs_in_ready", in_ready, 1'b1);
        sb.push_back(model(32'd11, 32'd13, 1'b0));
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk1("bp_new_accepted", in_ready, 1'b0);
        wait_done("bp_new", 1'b0);
        check_result("bp_new_value");
        handshake("bp_new");

        // Asynchronous reset in the middle of RUN
        start_op(32'd100, 32'd200, 1'b0);
        repeat (9) begin
            @(posedge clk); #1;
        end
        #2 rst = 1'b0;
        #1;
        chk1("midrst_out_valid", out_valid, 1'b0);
        chk64("midrst_prod", {prod_hi, prod_lo}, 64'h0);
        void'(sb.pop_back());
        #2 rst = 1'b1;
        #1;
        chk1("midrst_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        run_op("after_rst_7x9", 32'd7, 32'd9, 1'b0);
        chk64("after_rst_value", {prod_hi, prod_lo}, 64'd63);

        // Inputs churned during RUN must be ignored
        start_op(32'hCAFE_0001, 32'h0BAD_F00D, 1'b0);
        wait_done("toggle", 1'b1);
        check_result("toggle_value");
        handshake("toggle");

`ifdef ALU_MUL_SIGNED_EN
        run_op("s_m1xm1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        chk64("s_m1xm1_value", {prod_hi, prod_lo}, 64'h0000_0000_0000_0001);
        run_op("s_minxmin", 32'h8000_0000, 32'h8000_0000, 1'b1);
        chk64("s_minxmin_value", {prod_hi, prod_lo}, 64'h4000_0000_0000_0000);
        run_op("s_m3x5", 32'hFFFF_FFFD, 32'd5, 1'b1);
        chk64("s_m3x5_value", {prod_hi, prod_lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        run_op("s_off_m1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
`endif

        chk32("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/alu_seq_mul.md
Name: alu_seq_mul

Overview:
Iterative radix-2 shift-add multiplier for the processor ALU. It accepts one operand pair per operation and produces a 2*WIDTH-bit product after a fixed WIDTH-cycle latency. The block sits directly upstream of the ALU's 32-bit result pipeline register (dff_32): prod_lo feeds that register's d input on the out_valid/out_ready handshake.

Parameters:
WIDTH, 32, operand width in bits; the product is 2*WIDTH bits, split into prod_hi and prod_lo.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset (asserted when 0)
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept operands
a  input  WIDTH  multiplicand
b  input  WIDTH  multiplier
out_valid  output  1  product valid
out_ready  input  1  downstream consumes product
prod_lo  output  WIDTH  product bits [WIDTH-1:0]
prod_hi  output  WIDTH  product bits [2*WIDTH-1:WIDTH]

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low on rst.
- Reset (rst=0, any state, takes effect immediately): state=IDLE, iteration counter=0, accumulator=0, prod_lo=0, prod_hi=0, out_valid=0, in_ready=1 once rst is released. Any in-flight operation is discarded.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1, out_valid=0. When in_valid=1, operands are accepted at that edge: multiplicand<=a, multiplier<=b, acc_hi (WIDTH+1 bits)<=0, count<=0, go to RUN.
- RUN: in_ready=0. Each edge performs one step:
  - if multiplier lsb=1, acc_hi+=multiplicand (WIDTH+1-bit sum, carry kept);
  - shift {acc_hi,multiplier} right by 1;
  - count+=1.
  - After WIDTH steps (count==WIDTH-1 at the edge), load prod_hi/prod_lo from the final shifted value and go to DONE.
- Latency: out_valid rises exactly WIDTH edges after the accepting edge, independent of operand values. Zero operands do not terminate early.
- DONE: out_valid=1, in_ready=0. prod_hi/prod_lo are held stable until the edge where out_valid&&out_ready. At that edge the FSM goes to IDLE and out_valid drops. There is no same-cycle accept of a new operation, so the sustained rate is one operation per WIDTH+2 cycles.
- prod_hi/prod_lo retain the last product after handshake until the next DONE load or reset.
- in_valid during RUN/DONE: ignored, no side effects. a and b only need to be stable at the accepting edge.
- out_ready outside DONE: ignored.
- All arithmetic is modulo 2^(2*WIDTH); overflow is impossible because the full product width is output.

Optional Feature:
Macro ALU_MUL_SIGNED_EN.
- Defined:
  - Adds input port op_signed (1 bit), sampled at the accepting edge.
  - If op_signed=1, a and b are converted to magnitudes at accept, and neg=a[WIDTH-1]^b[WIDTH-1] is registered.
  - At the RUN->DONE edge the loaded 2*WIDTH result is two's-complement negated when neg=1.
  - Latency is unchanged.
  - Magnitude of the most negative value (2^(WIDTH-1)) is handled correctly as unsigned.
- Not defined: the op_signed port is absent and all operations are unsigned.

Test Plan:
- Basic: reset, then a=3, b=5 accepted -> out_valid=1 exactly 32 edges later, prod_hi=0x00000000, prod_lo=0x0000000F. out_ready=1 -> IDLE next edge, in_ready=1.
- Max unsigned: a=b=0xFFFFFFFF -> prod_hi=0xFFFFFFFE, prod_lo=0x00000001. a=0, b=0xFFFFFFFF -> product 0 with the same 32-cycle latency.
- Backpressure: hold out_ready=0 for 10 cycles in DONE, in_valid=1 with new operands -> outputs stable, in_ready=0, new operands not taken. Raise out_ready -> handshake, then new operands accepted in IDLE.
- Reset mid-op: drive rst=0 asynchronously at RUN step 10 -> out_valid=0, prod=0, in_ready=1 after release. A fresh 7*9 then yields 63 with full latency.
- Ignored input: toggle a/b/in_valid every cycle during RUN -> result equals product of operands sampled at the accepting edge.
- ALU_MUL_SIGNED_EN with op_signed=1:
  - -1*-1 -> prod_hi=0, prod_lo=1;
  - 0x80000000*0x80000000 -> prod_hi=0x40000000, prod_lo=0;
  - -3*5 -> prod_hi=0xFFFFFFFF, prod_lo=0xFFFFFFF1.
